// File: rtl/pooled_fmap_buffer.sv
// Captures one pooled three-channel feature map, then replays it as a single
// valid/ready stream in channel-major raster order before rearming for the next frame.
module pooled_fmap_buffer #(
  parameter  int DATA_BIT = 12,
  parameter  int FMAP_W   = 12,
  parameter  int FMAP_H   = 12,
  localparam int N        = FMAP_W * FMAP_H,
  localparam int AW       = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [DATA_BIT-1:0] data_in_1,
  input  logic [DATA_BIT-1:0] data_in_2,
  input  logic [DATA_BIT-1:0] data_in_3,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_BIT-1:0] out_data,
  output logic [1:0]          out_ch,
  output logic [AW-1:0]       out_addr,
  output logic                out_last,
  output logic                frame_done,
  output logic                overflow
);

  typedef enum logic [1:0] {FILL, LOAD, DRAIN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [1:0]    LAST_CH   = 2'd2;

  logic [DATA_BIT-1:0] mem_0 [N];
  logic [DATA_BIT-1:0] mem_1 [N];
  logic [DATA_BIT-1:0] mem_2 [N];

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [1:0]          rd_ch_q, rd_ch_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_BIT-1:0] out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;
  logic                mem_we;

  logic [1:0]          nxt_ch;
  logic [AW-1:0]       nxt_addr;
  logic [DATA_BIT-1:0] nxt_word;

  // Position of the word that follows the one currently presented.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    nxt_ch   = rd_ch_q;
    nxt_addr = rd_addr_q + AW'(1);
    if (rd_addr_q == LAST_ADDR) begin
      nxt_ch   = rd_ch_q + 2'd1;
      nxt_addr = '0;
    end
    case (nxt_ch)
      2'd0:    nxt_word = mem_0[nxt_addr];
      2'd1:    nxt_word = mem_1[nxt_addr];
      default: nxt_word = mem_2[nxt_addr];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_ch_d      = rd_ch_q;
    rd_addr_d    = rd_addr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    mem_we       = 1'b0;

    case (state_q)
      FILL: begin
        if (valid_in) begin
          mem_we = 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            wr_addr_d = '0;
            state_d   = LOAD;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end
      LOAD: begin
        out_data_d  = mem_0[0];
        rd_ch_d     = '0;
        rd_addr_d   = '0;
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        state_d     = DRAIN;
      end
      DRAIN: begin
        // Without a handshake every output register holds its value.
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            frame_done_d = 1'b1;
            rd_ch_d      = '0;
            rd_addr_d    = '0;
            state_d      = FILL;
          end else begin
            rd_ch_d    = nxt_ch;
            rd_addr_d  = nxt_addr;
            out_data_d = nxt_word;
            out_last_d = (nxt_ch == LAST_CH) && (nxt_addr == LAST_ADDR);
          end
        end
      end
      default: state_d = FILL;
    endcase

    // Upstream cannot stall, so pixels outside FILL are lost and flagged.
    if (valid_in && (state_q != FILL)) overflow_d = 1'b1;
  end

  // NOTE: frame storage has no reset; it is always fully rewritten before it is read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_0[wr_addr_q] <= data_in_1;
      mem_1[wr_addr_q] <= data_in_2;
      mem_2[wr_addr_q] <= data_in_3;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      wr_addr_q    <= '0;
      rd_ch_q      <= '0;
      rd_addr_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_ch_q      <= rd_ch_d;
      rd_addr_q    <= rd_addr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign in_ready   = (state_q == FILL);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ch     = rd_ch_q;
  assign out_addr   = rd_addr_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/pooled_fmap_buffer.md
# pooled_fmap_buffer

Frame buffer that sits downstream of the max-pool/ReLU stage and accepts its three parallel channel outputs, one pooled pixel per valid pulse. Once a full pooled feature map has been captured, the block replays it to the next layer as a single valid/ready stream in channel-major, raster order. It then rearms for the next frame. The upstream has no backpressure: writes that arrive while the buffer is draining are dropped and flagged.

## Interface
Parameters:
- DATA_BIT, 12: width of each pooled value (unsigned; ReLU output is non-negative).
- FMAP_W, 12: pooled feature-map width in pixels.
- FMAP_H, 12: pooled feature-map height in pixels; N = FMAP_W*FMAP_H, N >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- valid_in  input  1  one pooled pixel present on data_in_1..3 this cycle.
- data_in_1  input  DATA_BIT  channel 0 pooled value.
- data_in_2  input  DATA_BIT  channel 1 pooled value.
- data_in_3  input  DATA_BIT  channel 2 pooled value.
- in_ready  output  1  high while in FILL; informational only, upstream does not stall.
- out_valid  output  1  out_data and its tags are valid.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- out_data  output  DATA_BIT  pooled value being replayed.
- out_ch  output  2  channel of out_data (0..2).
- out_addr  output  clog2(N)  raster index of out_data (row*FMAP_W + col).
- out_last  output  1  high with the final word of the frame (ch 2, addr N-1).
- frame_done  output  1  one-cycle pulse after the final word is accepted.
- overflow  output  1  sticky: valid_in was seen outside FILL; cleared only by rst.

## Operation
- Storage: three arrays of N x DATA_BIT, one per channel, plus write pointer wr_addr and read pointers rd_ch, rd_addr.
- States: FILL, LOAD, DRAIN.
- FILL: on valid_in, each data_in_k is written to mem_k[wr_addr] and wr_addr increments. On the write at wr_addr == N-1, wr_addr wraps to 0 and the state goes to LOAD.
- LOAD (exactly one cycle): out_data <= mem_0[0], out_ch <= 0, out_addr <= 0, out_valid <= 1, out_last <= 0. The state goes to DRAIN.
- DRAIN, on handshake (out_valid && out_ready):
  - If the word is not last, load the next word into the output registers, incrementing rd_addr and moving to the next channel after N-1. out_valid stays 1, giving one word per cycle under continuous ready.
  - If out_last is set, out_valid <= 0, out_last <= 0, frame_done <= 1 for one cycle, read pointers clear, and the state goes to FILL.
- DRAIN without a handshake: all output registers hold their values (valid/ready stability rule).
- out_last is registered with the word and is high only when the loaded word is ch 2, addr N-1.
- valid_in in LOAD or DRAIN: data discarded, wr_addr unchanged, overflow <= 1.
- valid_in in the same cycle that frame_done is pulsed: the state is already FILL in that cycle, so the pixel is written normally to address 0.
- No arithmetic on data: values are stored and replayed bit-exact. Pointers wrap exactly at N-1 and at channel 2.

## Timing
- Reset (synchronous, evaluated on the clk edge, overrides everything):
  - state = FILL, pointers = 0.
  - out_valid = 0, out_data = 0, out_ch = 0, out_addr = 0, out_last = 0.
  - frame_done = 0, overflow = 0, in_ready = 1.
  - Array contents are not cleared.
- Reset mid-frame, during FILL or DRAIN, abandons the frame. The first valid_in after reset is written to address 0.
- Latency: the edge that stores the last pixel is edge E. State is LOAD after E, out_valid is high after E+1, and the first word is acceptable at edge E+2.
- Throughput: 3N accepted words in 3N consecutive cycles with out_ready held high. frame_done is high in the cycle after the final accept edge.
- in_ready = (state == FILL), combinational from state.

## Test plan
- Reset values: N=4 (FMAP_W=FMAP_H=2). Assert rst for 2 cycles -> every output at its reset value, in_ready=1, overflow=0.
- Fill and drain:
  - Stimulus: write pixels p=0..3 with data_in_k = 16*k + p, then hold out_ready=1.
  - Required: out_valid rises 2 cycles after the 4th write. Words appear as ch0: 16,17,18,19; ch1: 32..35; ch2: 48..51 on consecutive cycles. out_last is high only on 51, and frame_done pulses once the cycle after it.
- Backpressure: toggle out_ready 1,0,0,1 repeatedly -> out_data, out_ch, out_addr and out_last stay stable while out_ready=0. No word is lost or duplicated; the sequence is identical to the fill-and-drain case.
- Overflow: pulse valid_in with data 0xFFF during DRAIN -> overflow=1 and stays set. The replayed data is unchanged, and the next frame writes start at address 0.
- Back-to-back frames: drive valid_in in the frame_done cycle with value 7 -> it is stored at addr 0 of frame 2, and frame 2 replays starting with 7.
- Reset mid-drain: assert rst after 5 accepted words -> out_valid=0 next cycle and the state is FILL. A fresh 4-pixel frame then drains fully and correctly.
